// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared UART FIFO parameters and pointer-compare helpers
// Purpose: default FIFO depth, pointer width and the wrap-bit full/empty
//          compares used by both the RX and TX FIFOs.
// Contents:
//   FIFO_DEPTH_LOG2  default log2 of FIFO depth
//   FIFO_PTR_W       pointer width for the default depth (one extra wrap bit)
//   MAX_PTR_W        widest pointer the helpers accept (DEPTH_LOG2 up to 8)
//   ptr_empty()      pointers identical
//   ptr_full()       wrap bits differ, address bits equal
package uart_rx_fifo_pkg;

  localparam int FIFO_DEPTH_LOG2 = 4;
  localparam int FIFO_PTR_W      = FIFO_DEPTH_LOG2 + 1;
  localparam int MAX_PTR_W       = 9;

  // Callers zero-extend their pointers to MAX_PTR_W bits.
  function automatic logic ptr_empty(input logic [MAX_PTR_W-1:0] wr,
                                     input logic [MAX_PTR_W-1:0] rd);
    return (wr == rd);
  endfunction

  // With zero-extended pointers, full means the XOR is exactly the wrap bit.
  function automatic logic ptr_full(input logic [MAX_PTR_W-1:0] wr,
                                    input logic [MAX_PTR_W-1:0] rd,
                                    input int                   depth_log2);
    return ((wr ^ rd) == (MAX_PTR_W'(1) << depth_log2));
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - simple dual-port FIFO storage, sync write / async read
// Purpose: DATA_BITS x 2**ADDR_BITS array shared by the UART RX and TX FIFOs.
// Ports:
//   clk      in   1          write clock
//   wr_en    in   1          write enable
//   wr_addr  in   ADDR_BITS  write address
//   wr_data  in   DATA_BITS  write data
//   rd_addr  in   ADDR_BITS  read address
//   rd_data  out  DATA_BITS  combinational read data
module uart_fifo_mem #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FWFT byte FIFO with sticky overrun flag
// Purpose: buffers bytes strobed by the UART receiver and presents them
//          first-word-fall-through to the register interface.
// Ports:
//   i_clk          in   1             system clock
//   i_rst          in   1             synchronous active-high reset
//   i_wr_stb       in   1             push strobe (receiver data-ready)
//   i_wr_data      in   DATA_BITS     byte to push
//   i_rd_en        in   1             pop request, honoured when o_rd_valid
//   i_clr_overrun  in   1             clears sticky o_overrun
//   o_rd_data      out  DATA_BITS     head byte, 0 when empty
//   o_rd_valid     out  1             head byte valid
//   o_empty        out  1             no bytes held
//   o_full         out  1             2**DEPTH_LOG2 bytes held
//   o_count        out  DEPTH_LOG2+1  bytes held
//   o_overrun      out  1             sticky: a byte was dropped while full
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_stb,
  input  logic [DATA_BITS-1:0]  i_wr_data,
  input  logic                  i_rd_en,
  input  logic                  i_clr_overrun,
  output logic [DATA_BITS-1:0]  o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overrun
);

  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 overrun;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [DATA_BITS-1:0] mem_rd_data;

  assign empty = ptr_empty(MAX_PTR_W'(wr_ptr), MAX_PTR_W'(rd_ptr));
  assign full  = ptr_full(MAX_PTR_W'(wr_ptr), MAX_PTR_W'(rd_ptr), DEPTH_LOG2);

  assign pop  = i_rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = i_wr_stb && (!full || pop);
  assign drop = i_wr_stb && full && !pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Setting takes priority over a concurrent clear.
      if (drop) begin
        overrun <= 1'b1;
      end else if (i_clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

  uart_fifo_mem #(
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (DEPTH_LOG2)
  ) u_mem (
    .clk     (i_clk),
    .wr_en   (push && !i_rst),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (i_wr_data),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (mem_rd_data)
  );

  assign o_rd_data  = empty ? '0 : mem_rd_data;
  assign o_rd_valid = !empty;
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = wr_ptr - rd_ptr;
  assign o_overrun  = overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_stb = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic       model_ov = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .DEPTH_LOG2(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_wr_stb      (wr_stb),
    .i_wr_data     (wr_data),
    .i_rd_en       (rd_en),
    .i_clr_overrun (clr_overrun),
    .o_rd_data     (rd_data),
    .o_rd_valid    (rd_valid),
    .o_empty       (empty),
    .o_full        (full),
    .o_count       (count),
    .o_overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    int n;
    n = model_q.size();
    check("count",    32'(count),    32'(n));
    check("empty",    32'(empty),    32'(n == 0));
    check("full",     32'(full),     32'(n == DEPTH));
    check("rd_valid", 32'(rd_valid), 32'(n != 0));
    check("rd_data",  32'(rd_data),  (n != 0) ? 32'(model_q[0]) : 32'd0);
    check("overrun",  32'(overrun),  32'(model_ov));
  endtask

  // One clock: drive inputs, advance the model at the edge, check after it.
  task automatic cycle(input logic wr, input logic [7:0] d, input logic rd,
                       input logic clr, input logic rs);
    int  n;
    logic do_pop;
    logic dropped;
    wr_stb = wr; wr_data = d; rd_en = rd; clr_overrun = clr; rst = rs;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_ov = 1'b0;
    end else begin
      n       = model_q.size();
      do_pop  = rd && (n != 0);
      dropped = wr && (n == DEPTH) && !do_pop;
      if (dropped) model_ov = 1'b1;
      else if (clr) model_ov = 1'b0;
      if (do_pop) void'(model_q.pop_front());
      if (wr && !dropped) model_q.push_back(d);
    end
    #1;
    compare_all();
    wr_stb = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0; rst = 1'b0;
  endtask

  initial begin
    // 1: reset then idle
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);

    // 2: single byte FWFT, then pop
    cycle(1, 8'hA5, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);

    // 3/4: fill, overrun, clear-with-overrun, plain clear
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0, 0);
    cycle(1, 8'hEE, 0, 0, 0);
    cycle(1, 8'hEE, 0, 1, 0);
    cycle(0, 8'h00, 0, 1, 0);

    // 5: full with simultaneous push and pop, then drain
    cycle(1, 8'h55, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 0, 0);

    // 6: pop on empty, then reset with 5 bytes held, strobe in reset cycle
    cycle(0, 8'h00, 1, 0, 0);
    cycle(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 8'($urandom), 0, 0, 0);
    cycle(1, 8'h77, 0, 0, 1);
    cycle(0, 8'h00, 0, 0, 0);

    // 7: 40 pushes interleaved with random pops to force pointer wrap
    for (int i = 0; i < 40; i++) begin
      cycle(1, 8'($urandom), $urandom_range(0, 2) != 0, 0, 0);
      if ($urandom_range(0, 3) == 0) cycle(0, 8'h00, 1, 0, 0);
    end
    while (model_q.size() != 0) cycle(0, 8'h00, 1, 0, 0);

    // Randomised soak with occasional clears and resets
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
